// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO read arbiter.
package fifo_arb_pkg;

  // Read-scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    LATCH = 2'd2,
    VALID = 2'd3
  } arb_state_t;

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational rotating-priority picker: first requester after rr_last wins.
module fifo_rr_pick #(
  parameter int unsigned NUM_FIFOS = 4,
  parameter int unsigned ID_BITS   = 2
) (
  input  logic [NUM_FIFOS-1:0] req,
  input  logic [ID_BITS-1:0]   rr_last,
  output logic [ID_BITS-1:0]   winner,
  output logic                 any_req
);

  logic [NUM_FIFOS-1:0] rotated;
  logic                 found;

  // Rotate req so bit 0 is the index just after rr_last, then take the lowest set bit.
  always_comb begin
    rotated = NUM_FIFOS'({req, req} >> (32'(rr_last) + 32'd1));
    winner  = '0;
    found   = 1'b0;
    any_req = |req;
    for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
      if (!found && rotated[i]) begin
        winner = ID_BITS'((32'(rr_last) + 32'd1 + i) % NUM_FIFOS);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Round-robin read scheduler sharing one consumer between several FIFOs,
// with an optional per-grant burst quantum.
module fifo_read_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_FIFOS  = 4,
  parameter int unsigned ID_BITS    = 2,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned BURST_BITS = 3
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_FIFOS-1:0]            port_enable,
  input  logic [NUM_FIFOS-1:0]            fifo_empty,
  input  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_q,
  output logic [NUM_FIFOS-1:0]            read_enable,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ID_BITS-1:0]              out_id
);

  arb_state_t             state;
  logic [ID_BITS-1:0]     grant;
  logic [ID_BITS-1:0]     rr_last;
  logic [BURST_BITS-1:0]  burst_cnt;

  logic [NUM_FIFOS-1:0]   req;
  logic [ID_BITS-1:0]     winner;
  logic                   any_req;
  logic [NUM_FIFOS-1:0]   win_oh;
  logic [NUM_FIFOS-1:0]   grant_oh;
  logic [DATA_WIDTH-1:0]  sel_q;
  logic                   grant_req;

  assign req       = port_enable & ~fifo_empty;
  assign grant_req = |(req & grant_oh);

  fifo_rr_pick #(
    .NUM_FIFOS (NUM_FIFOS),
    .ID_BITS   (ID_BITS)
  ) u_pick (
    .req     (req),
    .rr_last (rr_last),
    .winner  (winner),
    .any_req (any_req)
  );

  // One-hot decode of the fresh winner and the held grant, plus the granted q mux.
  always_comb begin
    win_oh   = '0;
    grant_oh = '0;
    sel_q    = '0;
    for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
      win_oh[i]   = (winner == ID_BITS'(i));
      grant_oh[i] = (grant == ID_BITS'(i));
      if (grant == ID_BITS'(i)) sel_q = fifo_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Read FSM: grant, single-cycle pop strobe, capture, then hold until accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      rr_last     <= ID_BITS'(NUM_FIFOS - 1);
      burst_cnt   <= '0;
      read_enable <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_id      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant       <= winner;
            read_enable <= win_oh;
            burst_cnt   <= '0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          read_enable <= '0;
          state       <= LATCH;
        end
        LATCH: begin
          out_data  <= sel_q;
          out_id    <= grant;
          out_valid <= 1'b1;
          burst_cnt <= burst_cnt + 1'b1;
          state     <= VALID;
        end
        VALID: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (burst_cnt < BURST_BITS'(BURST_LEN) && grant_req) begin
              read_enable <= grant_oh;
              state       <= ISSUE;
            end else begin
              rr_last <= grant;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_read_arbiter.md
Name: fifo_read_arbiter

Overview:
- Round-robin read scheduler that shares one downstream consumer between NUM_FIFOS instances of the team's fifo block, all clocked by one common clock.
- Watches each FIFO's fifo_empty flag and pulses exactly one read_enable at a time.
- Captures the selected FIFO's q output and presents it on a valid/ready output port.
- Supports an optional burst quantum: up to BURST_LEN consecutive words from the same FIFO before rotating.

Parameters:
- DATA_WIDTH, 32: word width; must match the FIFOs.
- NUM_FIFOS, 4: number of FIFOs arbitrated.
- ID_BITS, 2: width of the FIFO index; must satisfy 2^ID_BITS >= NUM_FIFOS.
- BURST_LEN, 4: maximum consecutive words from one FIFO per grant; must be >= 1.
- BURST_BITS, 3: burst counter width; must hold BURST_LEN.

Ports:
- clock  in  1  single system clock; also drives read_clock of every FIFO.
- reset  in  1  synchronous, active-high.
- port_enable  in  NUM_FIFOS  per-FIFO arbitration mask; 1 = eligible.
- fifo_empty  in  NUM_FIFOS  fifo_empty flags of the FIFOs.
- fifo_q  in  NUM_FIFOS*DATA_WIDTH  concatenated q outputs; FIFO i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- read_enable  out  NUM_FIFOS  one-hot-or-zero read strobes to the FIFOs.
- out_data  out  DATA_WIDTH  captured word.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts out_data.
- out_id  out  ID_BITS  source FIFO index of out_data.

Behaviour:
- Reset (checked on rising clock edge while reset=1):
  - state=IDLE; read_enable=0; out_valid=0; out_data=0; out_id=0; burst_cnt=0.
  - rr_last=NUM_FIFOS-1, so the first search starts at FIFO 0.
  - Reset mid-transaction aborts it. A word already popped from a FIFO is dropped; this is accepted behaviour.
- All outputs are registered. read_enable has at most one bit set in any cycle.
- Request vector: req = port_enable & ~fifo_empty.
- FSM states, all transitions on the rising clock edge:
  - IDLE: if req != 0, pick the winner: the first set bit scanning rr_last+1, rr_last+2, ... with modulo NUM_FIFOS wrap. Register grant=winner, set read_enable[winner]=1, burst_cnt=0, go to ISSUE. If req == 0, stay in IDLE.
  - ISSUE: read_enable asserted for exactly this one cycle; the FIFO pops at the end of the cycle. Next state is LATCH with read_enable=0.
  - LATCH: at the end of the cycle, out_data takes fifo_q[grant], out_id takes grant, out_valid goes to 1, and burst_cnt increments. Next state is VALID.
  - VALID: out_data and out_id stay stable while out_valid=1 and out_ready=0. On out_ready=1:
    - out_valid is cleared.
    - If burst_cnt < BURST_LEN and req[grant]=1, re-issue the same grant: read_enable[grant]=1, go to ISSUE.
    - Otherwise set rr_last=grant and go to IDLE.
- Latency: FIFO non-empty in IDLE leads to out_valid 3 cycles later (IDLE -> ISSUE -> LATCH -> VALID).
- Peak throughput: 1 word per 3 cycles within a burst when out_ready is held high.
- fifo_empty is sampled only in IDLE and VALID. That is at least one cycle after the previous pop, so the FIFO's flag update is already settled and no over-read occurs.
- port_enable changes take effect at the next IDLE or VALID decision; an in-flight read always completes. Deasserting port_enable[grant] ends the burst after the current word.
- Wrap-around: the scan covers all NUM_FIFOS indices. A sole requester equal to rr_last is still granted.
- out_ready while out_valid=0 is ignored.
- Indices >= NUM_FIFOS are never granted.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - state encoding localparams: IDLE=2'd0, ISSUE=2'd1, LATCH=2'd2, VALID=2'd3.
  - any helper for one-hot conversion.
- One natural sub-module, fifo_rr_pick: combinational rotating priority picker.
  - Inputs: req[NUM_FIFOS], rr_last[ID_BITS].
  - Outputs: winner[ID_BITS], any_req.
- The top level holds the FSM, burst counter, capture register and output handshake.

Test Plan:
- Reset with FIFO 2 non-empty, port_enable=4'b1111, out_ready=1:
  - read_enable=4'b0100 in the cycle after IDLE sees the request.
  - out_valid rises 2 cycles after that with out_id=2 and out_data equal to the FIFO 2 head word (e.g. 32'hA5A5_0002).
- All four FIFOs hold 1 word each (0x10, 0x20, 0x30, 0x40), out_ready=1:
  - outputs arrive in order out_id 0,1,2,3 with the matching data.
  - read_enable is never multi-hot.
- FIFO 1 holds 6 words, FIFO 3 holds 2, BURST_LEN=4:
  - out_id sequence is 1,1,1,1,3,3,1,1.
- out_ready held 0 for 5 cycles in VALID:
  - out_valid, out_data and out_id stay constant.
  - read_enable stays 0 until out_ready rises.
- port_enable=4'b0101 with all FIFOs non-empty:
  - only ids 0 and 2 are granted.
  - clearing bit 0 mid-burst on FIFO 0 ends that burst after the current word.
- Assert reset for 1 cycle while in LATCH:
  - next cycle out_valid=0, read_enable=0, state IDLE.
  - the next grant starts search at FIFO 0.
